edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_evt_pkg.sv | 8 +
 rtl/edge_capture_ch.sv | 35 +++
 rtl/edge_event_arbiter.sv | 82 ++++++++
 tb/tb_edge_event_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg: shared defaults, FSM encoding and edge-type constants for the edge event arbiter
package edge_evt_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int CH_W_DEF = 2;
  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;
  typedef enum logic {IDLE, PRESENT} state_t;
endpackage

// File: rtl/edge_capture_ch.sv
// edge_capture_ch: one channel's edge detector with priming cycle, pending bit and stored edge type
module edge_capture_ch
  import edge_evt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic en,
  input  logic clr,
  output logic pending,
  output logic rise,
  output logic drop
);
  logic prev, primed, hit;
  assign hit = primed & en & (sig ^ prev);
  assign drop = hit & pending & ~clr;
  // a clear coinciding with a new edge re-arms with that edge instead of losing it
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      primed <= 1'b0;
      pending <= 1'b0;
      rise <= EDGE_FALL;
    end else begin
      prev <= sig;
      primed <= 1'b1;
      if (hit && (!pending || clr)) begin
        pending <= 1'b1;
        rise <= sig ? EDGE_RISE : EDGE_FALL;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge capture with round-robin event presentation over a valid/ready port
// Define EDGE_EVT_OVERFLOW_EN to add sticky per-channel dropped-edge flags (ovf) with a clear input (ovf_clr).
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W = CH_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] signal_in,
  input  logic [NUM_CH-1:0] ch_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_rise
`ifdef EDGE_EVT_OVERFLOW_EN
  ,
  output logic [NUM_CH-1:0] ovf,
  input  logic              ovf_clr
`endif
);
  state_t state, nxt;
  logic [NUM_CH-1:0] pending, rise, drop, clr;
  logic [CH_W-1:0] last, win;
  logic found, load;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    edge_capture_ch u_cap (
      .clk(clk),
      .rst(rst),
      .sig(signal_in[c]),
      .en(ch_en[c]),
      .clr(clr[c]),
      .pending(pending[c]),
      .rise(rise[c]),
      .drop(drop[c])
    );
  end
  // channels above the last grant are searched first, then wrap to channel 0
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (!found && pending[i] && CH_W'(i) > last) begin
        win = CH_W'(i);
        found = 1'b1;
      end
    for (int i = 0; i < NUM_CH; i++)
      if (!found && pending[i] && CH_W'(i) <= last) begin
        win = CH_W'(i);
        found = 1'b1;
      end
  end
  always_comb begin
    load = (state == IDLE) && found;
    nxt = state == IDLE ? (found ? PRESENT : IDLE) : (evt_ready ? IDLE : PRESENT);
    clr = load ? NUM_CH'(1) << win : '0;
  end
  assign evt_valid = state == PRESENT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= CH_W'(NUM_CH - 1);
      evt_ch <= '0;
      evt_rise <= EDGE_FALL;
    end else begin
      state <= nxt;
      if (load) begin
        last <= win;
        evt_ch <= win;
        evt_rise <= rise[win];
      end
    end
  end
`ifdef EDGE_EVT_OVERFLOW_EN
  always_ff @(posedge clk)
    ovf <= rst ? '0 : (ovf & ~{NUM_CH{ovf_clr}}) | drop;
`else
  logic unused_drop;
  assign unused_drop = ^drop;
`endif
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: scoreboard bench for edge_event_arbiter (ovf checks when EDGE_EVT_OVERFLOW_EN is defined)
module tb_edge_event_arbiter;
  localparam int NUM_CH = 4;
  localparam int CH_W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic evt_ready = 1'b0;
  logic [NUM_CH-1:0] signal_in = '0;
  logic [NUM_CH-1:0] ch_en = '1;
  logic evt_valid, evt_rise;
  logic [CH_W-1:0] evt_ch;
`ifdef EDGE_EVT_OVERFLOW_EN
  logic [NUM_CH-1:0] ovf;
  logic ovf_clr = 1'b0;
`endif
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [CH_W:0] sb[$];
  logic [CH_W:0] exp_e;
  int hs_q[$];

  edge_event_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk),
    .rst(rst),
    .signal_in(signal_in),
    .ch_en(ch_en),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch(evt_ch),
    .evt_rise(evt_rise)
`ifdef EDGE_EVT_OVERFLOW_EN
    ,
    .ovf(ovf),
    .ovf_clr(ovf_clr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // every accepted handshake is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      hs_q.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got ch=%0d rise=%0b expected none", evt_ch, evt_rise);
      end else begin
        exp_e = sb.pop_front();
        if ({evt_ch, evt_rise} !== exp_e) begin
          failures++;
          $display("FAIL event_order got ch=%0d rise=%0b expected ch=%0d rise=%0b",
                   evt_ch, evt_rise, exp_e[CH_W:1], exp_e[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    signal_in = '0;
    ch_en = '1;
    evt_ready = 1'b0;
`ifdef EDGE_EVT_OVERFLOW_EN
    ovf_clr = 1'b0;
`endif
    tick(2);
    rst = 1'b0;
    sb.delete();
    hs_q.delete();
    tick(1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    signal_in = '0;
    tick(2);
    checks++;
    if ({evt_valid, evt_ch, evt_rise} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got %b expected 0000", {evt_valid, evt_ch, evt_rise});
    end
`ifdef EDGE_EVT_OVERFLOW_EN
    checks++;
    if (ovf !== '0) begin
      failures++;
      $display("FAIL reset_ovf got %b expected 0000", ovf);
    end
`endif
  endtask

  task automatic test_prime();
    rst = 1'b1;
    signal_in = '1;
    tick(2);
    rst = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL prime_valid cycle %0d got %b expected 0", i, evt_valid);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    evt_ready = 1'b1;
    signal_in[1] = 1'b1;
    sb.push_back({2'd1, 1'b1});
    tick(1);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_capture_cycle got valid=%b expected 0", evt_valid);
    end
    tick(1);
    checks++;
    if ({evt_valid, evt_ch, evt_rise} !== 4'b1011) begin
      failures++;
      $display("FAIL single_present got %b expected 1011", {evt_valid, evt_ch, evt_rise});
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL single_release got valid=%b left=%0d expected 0/0", evt_valid, sb.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    evt_ready = 1'b1;
    signal_in = 4'b1101;
    sb.push_back({2'd0, 1'b1});
    sb.push_back({2'd2, 1'b1});
    sb.push_back({2'd3, 1'b1});
    tick(1);
    signal_in[0] = 1'b0;
    sb.push_back({2'd0, 1'b0});
    wait_drain();
    tick(2);
    checks++;
    if (sb.size() != 0 || hs_q.size() != 4) begin
      failures++;
      $display("FAIL rr_count got left=%0d grants=%0d expected 0/4", sb.size(), hs_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (hs_q[i] - hs_q[i-1] !== 2) begin
          failures++;
          $display("FAIL rr_spacing grant %0d got %0d cycles expected 2", i, hs_q[i] - hs_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    evt_ready = 1'b1;
    signal_in[2] = 1'b1;
    sb.push_back({2'd2, 1'b1});
    wait_drain();
    tick(2);
    evt_ready = 1'b0;
    signal_in[0] = 1'b1;
    sb.push_back({2'd0, 1'b1});
    tick(2);
    checks++;
    if ({evt_valid, evt_ch, evt_rise} !== 4'b1001) begin
      failures++;
      $display("FAIL drop_blocker got %b expected 1001", {evt_valid, evt_ch, evt_rise});
    end
    signal_in[2] = 1'b0;
    sb.push_back({2'd2, 1'b0});
    tick(1);
    signal_in[2] = 1'b1;
    tick(2);
`ifdef EDGE_EVT_OVERFLOW_EN
    checks++;
    if (ovf !== 4'b0100) begin
      failures++;
      $display("FAIL drop_ovf_set got %b expected 0100", ovf);
    end
`endif
    evt_ready = 1'b1;
    wait_drain();
    tick(4);
    checks++;
    if (evt_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL drop_idle got valid=%b left=%0d expected 0/0", evt_valid, sb.size());
    end
`ifdef EDGE_EVT_OVERFLOW_EN
    checks++;
    if (ovf !== 4'b0100) begin
      failures++;
      $display("FAIL drop_ovf_sticky got %b expected 0100", ovf);
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin
      failures++;
      $display("FAIL drop_ovf_clr got %b expected 0000", ovf);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    signal_in = 4'b1100;
    tick(2);
    checks++;
    if ({evt_valid, evt_ch, evt_rise} !== 4'b1101) begin
      failures++;
      $display("FAIL mid_present got %b expected 1101", {evt_valid, evt_ch, evt_rise});
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if ({evt_valid, evt_ch, evt_rise} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset got %b expected 0000", {evt_valid, evt_ch, evt_rise});
    end
    rst = 1'b0;
    tick(1);
    signal_in = 4'b0110;
    sb.push_back({2'd1, 1'b1});
    sb.push_back({2'd3, 1'b0});
    evt_ready = 1'b1;
    wait_drain();
    tick(3);
    checks++;
    if (evt_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL mid_after got valid=%b left=%0d expected 0/0", evt_valid, sb.size());
    end
  endtask

  task automatic test_ch_en();
    do_reset();
    signal_in[0] = 1'b1;
    sb.push_back({2'd0, 1'b1});
    tick(2);
    signal_in[1] = 1'b1;
    sb.push_back({2'd1, 1'b1});
    tick(1);
    ch_en[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      signal_in[1] = ~signal_in[1];
      tick(1);
    end
    evt_ready = 1'b1;
    wait_drain();
    tick(3);
    for (int i = 0; i < 4; i++) begin
      signal_in[1] = ~signal_in[1];
      tick(1);
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL chen_gated cycle %0d got valid=%b expected 0", i, evt_valid);
      end
    end
    tick(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL chen_pending_kept got left=%0d expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_single();
    test_round_robin();
    test_drop();
    test_reset_mid();
    test_ch_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
